// File: rtl/rr_sel4_arbiter_pkg.sv
// Shared types and helpers for the rr_sel4_arbiter slice.
// Round-robin pick and one-hot helpers used by the arbiter FSM.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    // Scan ptr+1 .. ptr+4 (mod 4); the first set request wins.
    function automatic pick_t rr_pick(
        input logic [N_REQ-1:0] req,
        input sel_t             ptr
    );
        pick_t p;
        sel_t  idx;
        p = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr + sel_t'(k);
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input sel_t s);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_sel4_arbiter_if.sv
// Requester-side bundle of the 4:1 round-robin arbiter.
// master = requester logic, slave = arbiter.
interface rr_sel4_arbiter_if #(
    parameter int DATA_W = 1
);
    import arb_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    sel_t                    sel;
    logic                    grant_valid;
    logic [DATA_W-1:0]       data_out;

    modport master (
        output req, data_in,
        input  grant, sel, grant_valid, data_out
    );

    modport slave (
        input  req, data_in,
        output grant, sel, grant_valid, data_out
    );

endinterface

// File: rtl/rr_sel4_arbiter_sel4_mux.sv
// Pure combinational 4:1 selector of DATA_W-bit slices.
module sel4_mux
    import arb_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [N_REQ*DATA_W-1:0] data_i,
    input  sel_t                    sel_i,
    output logic [DATA_W-1:0]       data_o
);

    always_comb begin
        data_o = '0;
        unique case (sel_i)
            2'd0: data_o = data_i[0*DATA_W +: DATA_W];
            2'd1: data_o = data_i[1*DATA_W +: DATA_W];
            2'd2: data_o = data_i[2*DATA_W +: DATA_W];
            2'd3: data_o = data_i[3*DATA_W +: DATA_W];
        endcase
    end

endmodule

// File: rtl/rr_sel4_arbiter.sv
// Round-robin arbiter/sequencer for the 4:1 selector datapath.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD owner cycles.
module rr_sel4_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input logic              clk,
    input logic              rst,
    rr_sel4_arbiter_if.slave bus
);

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    arb_state_t       state_q;
    logic [N_REQ-1:0] grant_q;
    sel_t             sel_q;
    sel_t             ptr_q;
    logic             valid_q;
    logic             own_req;
    pick_t            pick_all;
    logic [DATA_W-1:0] mux_out;

    assign own_req  = bus.req[sel_q];
    assign pick_all = rr_pick(bus.req, ptr_q);

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q;
    pick_t             pick_oth;

    // Owner is masked so a timeout only ever hands off to a competitor.
    assign pick_oth = rr_pick(bus.req & ~onehot(sel_q), ptr_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= 2'd3;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_all.found) begin
                        state_q <= GRANT;
                        grant_q <= onehot(pick_all.idx);
                        sel_q   <= pick_all.idx;
                        ptr_q   <= pick_all.idx;
                        valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!own_req) begin
                        if (pick_all.found) begin
                            grant_q <= onehot(pick_all.idx);
                            sel_q   <= pick_all.idx;
                            ptr_q   <= pick_all.idx;
`ifdef ARB_TIMEOUT_EN
                            hold_q  <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            valid_q <= 1'b0;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_q == HOLD_MAX && pick_oth.found) begin
                        grant_q <= onehot(pick_oth.idx);
                        sel_q   <= pick_oth.idx;
                        ptr_q   <= pick_oth.idx;
                        hold_q  <= '0;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q  <= hold_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sel4_mux #(
        .DATA_W(DATA_W)
    ) u_mux (
        .data_i(bus.data_in),
        .sel_i (sel_q),
        .data_o(mux_out)
    );

    assign bus.grant       = grant_q;
    assign bus.sel         = sel_q;
    assign bus.grant_valid = valid_q;
    assign bus.data_out    = valid_q ? mux_out : '0;

endmodule

// File: tb/tb_rr_sel4_arbiter.sv
// Self-checking bench for rr_sel4_arbiter: vector table, corner
// sequences and randomized traffic against an ownership model.
module tb_rr_sel4_arbiter;
    import arb_pkg::*;

    localparam int MAX_HOLD = 8;

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic       d;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_sel4_arbiter_if #(.DATA_W(1)) bus ();

    rr_sel4_arbiter #(
        .DATA_W  (1),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: who owns the output, where the search resumes, hold age.
    bit m_valid;
    int m_sel;
    int m_ptr;
    int m_hold;

    function automatic int scan(input logic [3:0] r, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_sel   = 0;
        m_ptr   = 3;
        m_hold  = 0;
    endtask

    task automatic grant_to(input int w);
        m_valid = 1;
        m_sel   = w;
        m_ptr   = w;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        logic [3:0] oth;
        w = scan(r, m_ptr);
        oth = r;
        if (!m_valid) begin
            if (w >= 0) grant_to(w);
        end else if (!r[m_sel]) begin
            if (w >= 0) grant_to(w);
            else m_valid = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            oth[m_sel] = 1'b0;
            w = scan(oth, m_ptr);
            if (m_hold == MAX_HOLD - 1 && w >= 0) grant_to(w);
            else if (m_hold < MAX_HOLD - 1) m_hold++;
`else
            oth = '0;
`endif
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [3:0] eg;
        logic       ed;
        eg = m_valid ? (4'b0001 << m_sel) : 4'b0000;
        ed = m_valid ? bus.data_in[m_sel] : 1'b0;
        chk({tag, ".grant"}, 8'(bus.grant), 8'(eg));
        chk({tag, ".sel"}, 8'(bus.sel), 8'(m_sel));
        chk({tag, ".valid"}, 8'(bus.grant_valid), 8'(m_valid));
        chk({tag, ".dout"}, 8'(bus.data_out), 8'(ed));
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] din);
        bus.req     = r;
        bus.data_in = din;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tbl[12];

    initial begin
        logic [3:0] r;
        logic [3:0] d;
        tbl = '{
            '{4'b0000, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{4'b0000, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{4'b0000, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{4'b0000, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{4'b0000, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b0},
            '{4'b1111, 4'b0101, 4'b0001, 2'b00, 1'b1, 1'b1},
            '{4'b1110, 4'b0101, 4'b0010, 2'b01, 1'b1, 1'b0},
            '{4'b1101, 4'b0101, 4'b0100, 2'b10, 1'b1, 1'b1},
            '{4'b1011, 4'b0101, 4'b1000, 2'b11, 1'b1, 1'b0},
            '{4'b0111, 4'b0101, 4'b0001, 2'b00, 1'b1, 1'b1},
            '{4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1},
            '{4'b0000, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0}
        };

        rst         = 1'b1;
        bus.req     = '0;
        bus.data_in = '0;
        model_reset();
        #1;
        chk("rst.grant", 8'(bus.grant), 8'h00);
        chk("rst.valid", 8'(bus.grant_valid), 8'h00);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, tbl[i].din);
            chk($sformatf("tbl%0d.grant", i), 8'(bus.grant), 8'(tbl[i].g));
            chk($sformatf("tbl%0d.sel", i), 8'(bus.sel), 8'(tbl[i].s));
            chk($sformatf("tbl%0d.valid", i), 8'(bus.grant_valid),
                8'(tbl[i].v));
            chk($sformatf("tbl%0d.dout", i), 8'(bus.data_out), 8'(tbl[i].d));
        end

        // B releases as C rises with D pending: C next, no bubble.
        do_reset();
        step(4'b0010, 4'b1111);
        chk("rel.b", 8'(bus.grant), 8'h02);
        step(4'b1100, 4'b1111);
        chk("rel.c", 8'(bus.grant), 8'h04);
        chk("rel.valid", 8'(bus.grant_valid), 8'h01);
        chk_model("rel");

        // Asynchronous reset in the middle of C's grant.
        do_reset();
        step(4'b0100, 4'b0100);
        chk("arst.pre", 8'(bus.grant), 8'h04);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.grant", 8'(bus.grant), 8'h00);
        chk("arst.sel", 8'(bus.sel), 8'h00);
        chk("arst.valid", 8'(bus.grant_valid), 8'h00);
        chk("arst.dout", 8'(bus.data_out), 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 4'b0001);
        chk("arst.first", 8'(bus.grant), 8'h01);
        chk_model("arst");

        // A holds while B and D compete.
        do_reset();
        step(4'b0001, 4'b0000);
        for (int i = 1; i <= 20; i++) begin
            step(4'b1011, 4'b0000);
            chk_model($sformatf("hold%0d", i));
        end
`ifdef ARB_TIMEOUT_EN
        chk("hold.final", 8'(bus.grant), 8'h08);
`else
        chk("hold.final", 8'(bus.grant), 8'h01);
`endif

        do_reset();
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) r = 4'($urandom);
            d = 4'($urandom);
            step(r, d);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
